// File: rtl/nios2_debug_ocimem_sequencer_if.sv
// Debug-memory sequencer bus bundle: the JTAG-side command strobes, the
// debug-memory master port and the monitor result returned to the debug slave.
interface nios2_debug_ocimem_sequencer_if;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [37:0] jdo;
  logic        debugack;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic [7:0]  mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;
  logic        busy;

  modport slave (
    input  take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
    input  jdo, debugack, mem_readdata, mem_waitrequest,
    output mem_address, mem_read, mem_write, mem_writedata,
    output MonDReg, monitor_ready, monitor_error, busy
  );

  modport master (
    output take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
    output jdo, debugack, mem_readdata, mem_waitrequest,
    input  mem_address, mem_read, mem_write, mem_writedata,
    input  MonDReg, monitor_ready, monitor_error, busy
  );
endinterface

// File: rtl/nios2_debug_ocimem_sequencer.sv
// Nios II debug OCI-memory access sequencer. Turns one-cycle JTAG command
// strobes into single debug-memory reads/writes with an auto-incrementing
// address and reports the outcome through MonDReg/monitor_ready/monitor_error.
// Optional stall watchdog: define NIOS2_DEBUG_OCIMEM_TIMEOUT_EN to abort an
// access after TIMEOUT_CYCLES cycles of mem_waitrequest.
module nios2_debug_ocimem_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                           clk,
  input logic                           reset_n,
  nios2_debug_ocimem_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic        incr_q, incr_d;   // bump ADDR when the current access completes
  logic        ready_q, ready_d, err_q, err_d;
  logic [31:0] wdata_q, wdata_d, mon_q, mon_d;
  logic        any_strobe, tmo_hit;

  assign any_strobe = bus.take_action_ocimem_a | bus.take_action_ocimem_b |
                      bus.take_no_action_ocimem_a;

`ifdef NIOS2_DEBUG_OCIMEM_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
  // Abort on the stall cycle that brings the count up to the limit.
  assign tmo_hit = bus.mem_waitrequest && ((int'(tmo_q) + 1) >= TIMEOUT_CYCLES);
  logic unused_ok;
  assign unused_ok = ^{bus.jdo[37:36], bus.jdo[2:0]};
`else
  assign tmo_hit = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{bus.jdo[37:36], bus.jdo[2:0], (TIMEOUT_CYCLES == 0)};
`endif

  // Next-state: strobe decode in IDLE, completion/abort/overrun while busy.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    incr_d  = incr_q;
    ready_d = ready_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    mon_d   = mon_q;
`ifdef NIOS2_DEBUG_OCIMEM_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef NIOS2_DEBUG_OCIMEM_TIMEOUT_EN
        tmo_d = 8'd0;
`endif
        if (bus.take_action_ocimem_a) begin
          addr_d  = bus.jdo[17:10];
          ready_d = 1'b0;
          err_d   = 1'b0;
          if (bus.jdo[35]) begin
            state_d = RD;
            rd_d    = 1'b1;
            incr_d  = 1'b0;
          end
        end else if (bus.take_action_ocimem_b) begin
          if (bus.debugack) begin
            wdata_d = bus.jdo[34:3];
            ready_d = 1'b0;
            state_d = WR;
            wr_d    = 1'b1;
            incr_d  = 1'b1;
          end else begin
            // CPU not halted: refuse the write without touching the bus.
            err_d   = 1'b1;
            ready_d = 1'b1;
          end
        end else if (bus.take_no_action_ocimem_a) begin
          ready_d = 1'b0;
          state_d = RD;
          rd_d    = 1'b1;
          incr_d  = 1'b1;
        end
      end
      RD, WR: begin
        if (any_strobe) err_d = 1'b1;  // overrun: command dropped
        if (tmo_hit) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          mon_d   = 32'hDEADDEAD;
          err_d   = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end else if (!bus.mem_waitrequest) begin
          if (state_q == RD) mon_d = bus.mem_readdata;
          if (incr_q) addr_d = addr_q + 8'd1;
          ready_d = 1'b1;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = IDLE;
        end else begin
`ifdef NIOS2_DEBUG_OCIMEM_TIMEOUT_EN
          tmo_d = tmo_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= 8'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      incr_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= 32'd0;
      mon_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      incr_q  <= incr_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      mon_q   <= mon_d;
    end
  end

`ifdef NIOS2_DEBUG_OCIMEM_TIMEOUT_EN
  // Stall counter for the current access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmo_q <= 8'd0;
    else          tmo_q <= tmo_d;
  end
`endif

  assign bus.mem_address   = addr_q;
  assign bus.mem_read      = rd_q;
  assign bus.mem_write     = wr_q;
  assign bus.mem_writedata = wdata_q;
  assign bus.MonDReg       = mon_q;
  assign bus.monitor_ready = ready_q;
  assign bus.monitor_error = err_q;
  assign bus.busy          = (state_q != IDLE);
endmodule

// File: tb/tb_nios2_debug_ocimem_sequencer.sv
// Bench for the OCI-memory sequencer: directed commands push expected bus
// completions and monitor results into queues; a negedge monitor pops and
// compares them as the DUT produces them.
module tb_nios2_debug_ocimem_sequencer;
  logic clk, reset_n;
  nios2_debug_ocimem_sequencer_if bus ();

  nios2_debug_ocimem_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [63:0] exp_bus[$];  // {write, address, write data (0 for reads)}
  logic [63:0] exp_res[$];  // {monitor_error, MonDReg}
  logic        prev_ready;
  int          cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [37:0] jload(input logic rd, input logic [7:0] a);
    logic [37:0] j;
    j = '0; j[17:10] = a; j[35] = rd;
    return j;
  endfunction

  function automatic logic [37:0] jwr(input logic [31:0] d);
    logic [37:0] j;
    j = '0; j[34:3] = d;
    return j;
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic strobe(input logic a, input logic b, input logic na, input logic [37:0] j);
    bus.take_action_ocimem_a = a;
    bus.take_action_ocimem_b = b;
    bus.take_no_action_ocimem_a = na;
    bus.jdo = j;
    tick;
    bus.take_action_ocimem_a = 1'b0;
    bus.take_action_ocimem_b = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
  endtask

  // Monitor: bus completions and monitor_ready rising edges.
  always @(negedge clk) begin
    if (!reset_n) prev_ready <= 1'b0;
    else begin
      if ((bus.mem_read || bus.mem_write) && !bus.mem_waitrequest) begin
        if (exp_bus.size() == 0) chk("bus_unexpected", 64'(exp_bus.size()), 64'd1);
        else chk("bus_access",
                 64'({bus.mem_write, bus.mem_address, bus.mem_write ? bus.mem_writedata : 32'd0}),
                 exp_bus.pop_front());
      end
      if (bus.monitor_ready && !prev_ready) begin
        if (exp_res.size() == 0) chk("res_unexpected", 64'(exp_res.size()), 64'd1);
        else chk("monitor_result", 64'({bus.monitor_error, bus.MonDReg}), exp_res.pop_front());
      end
      prev_ready <= bus.monitor_ready;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus.take_action_ocimem_a = 1'b0;
    bus.take_action_ocimem_b = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    bus.jdo = '0;
    bus.debugack = 1'b0;
    bus.mem_readdata = '0;
    bus.mem_waitrequest = 1'b0;
    #3;
    chk("reset_outputs", 64'({bus.mem_read, bus.mem_write, bus.busy, bus.monitor_ready,
                              bus.monitor_error, bus.mem_address}), 64'd0);
    chk("reset_data", 64'({bus.MonDReg, bus.mem_writedata}), 64'd0);
    tick; tick;
    reset_n = 1'b1;
    tick;

    // Load 0x10 with read-after-load, zero-wait.
    bus.mem_readdata = 32'h12345678;
    exp_bus.push_back(64'({1'b0, 8'h10, 32'h0}));
    exp_res.push_back(64'({1'b0, 32'h12345678}));
    strobe(1, 0, 0, jload(1'b1, 8'h10));
    chk("load_rd_n1", 64'({bus.mem_read, bus.busy, bus.mem_address}), 64'({2'b11, 8'h10}));
    tick;
    chk("load_rd_n2", 64'({bus.mem_read, bus.monitor_ready, bus.busy, bus.mem_address}),
        64'({3'b010, 8'h10}));

    // Read at current ADDR then increment.
    bus.mem_readdata = 32'hCAFEF00D;
    exp_bus.push_back(64'({1'b0, 8'h10, 32'h0}));
    exp_res.push_back(64'({1'b0, 32'hCAFEF00D}));
    strobe(0, 0, 1, '0);
    tick;
    chk("rd_incr_addr", 64'(bus.mem_address), 64'h11);

    // Write at 0xFF with three stall cycles; ADDR wraps.
    strobe(1, 0, 0, jload(1'b0, 8'hFF));
    chk("load_noread", 64'({bus.busy, bus.mem_address}), 64'({1'b0, 8'hFF}));
    bus.debugack = 1'b1;
    bus.mem_waitrequest = 1'b1;
    exp_bus.push_back(64'({1'b1, 8'hFF, 32'hA5A5A5A5}));
    exp_res.push_back(64'({1'b0, 32'hCAFEF00D}));
    strobe(0, 1, 0, jwr(32'hA5A5A5A5));
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.mem_write) cnt++;
      if (cnt == 4) bus.mem_waitrequest = 1'b0;
      tick;
    end
    bus.mem_waitrequest = 1'b0;
    chk("wr_hold_cycles", 64'(cnt), 64'd4);
    chk("wr_wrap", 64'({bus.monitor_ready, bus.mem_address}), 64'({1'b1, 8'h00}));

    // Write refused without debugack; load clears the error.
    strobe(1, 0, 0, jload(1'b0, 8'h20));
    bus.debugack = 1'b0;
    exp_res.push_back(64'({1'b1, 32'hCAFEF00D}));
    strobe(0, 1, 0, jwr(32'h11111111));
    chk("reject_flags", 64'({bus.mem_write, bus.busy, bus.monitor_error, bus.monitor_ready}),
        64'b0011);
    tick;
    strobe(1, 0, 0, jload(1'b0, 8'h20));
    chk("err_cleared", 64'(bus.monitor_error), 64'd0);

    // Simultaneous b + no_action: write wins; then overrun while busy.
    bus.debugack = 1'b1;
    bus.mem_waitrequest = 1'b1;
    exp_bus.push_back(64'({1'b1, 8'h20, 32'h5A5A0001}));
    exp_res.push_back(64'({1'b1, 32'hCAFEF00D}));
    strobe(0, 1, 1, jwr(32'h5A5A0001));
    chk("prio_write", 64'({bus.mem_write, bus.mem_read}), 64'b10);
    strobe(0, 0, 1, '0);
    chk("overrun_err", 64'({bus.monitor_error, bus.mem_write}), 64'b11);
    bus.mem_waitrequest = 1'b0;
    tick; tick;
    chk("after_overrun_addr", 64'(bus.mem_address), 64'h21);

    // Long stall on a read.
    strobe(1, 0, 0, jload(1'b0, 8'h21));
    bus.mem_waitrequest = 1'b1;
`ifdef NIOS2_DEBUG_OCIMEM_TIMEOUT_EN
    exp_res.push_back(64'({1'b1, 32'hDEADDEAD}));
    strobe(0, 0, 1, '0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.mem_read) cnt++;
      tick;
    end
    bus.mem_waitrequest = 1'b0;
    chk("timeout_stall_cycles", 64'(cnt), 64'd4);
    chk("timeout_addr", 64'({bus.busy, bus.mem_address}), 64'({1'b0, 8'h21}));
`else
    exp_bus.push_back(64'({1'b0, 8'h21, 32'h0}));
    exp_res.push_back(64'({1'b0, 32'h0BADF00D}));
    strobe(0, 0, 1, '0);
    cnt = 0;
    for (int i = 0; i < 120; i++) begin
      if (bus.mem_read) cnt++;
      tick;
    end
    chk("stall_read_held", 64'(cnt), 64'd120);
    bus.mem_readdata = 32'h0BADF00D;
    bus.mem_waitrequest = 1'b0;
    tick; tick;
    chk("stall_read_addr", 64'(bus.mem_address), 64'h22);
`endif

    // Reset during a stalled write aborts it immediately.
    bus.mem_waitrequest = 1'b1;
    strobe(0, 1, 0, jwr(32'h77777777));
    chk("wr_before_reset", 64'(bus.mem_write), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_ctl", 64'({bus.mem_write, bus.mem_read, bus.busy, bus.monitor_ready,
                                bus.monitor_error, bus.mem_address}), 64'd0);
    chk("async_reset_data", 64'({bus.MonDReg, bus.mem_writedata}), 64'd0);
    tick;
    reset_n = 1'b1;
    bus.mem_waitrequest = 1'b0;
    bus.mem_readdata = 32'h600D600D;
    tick;
    exp_bus.push_back(64'({1'b0, 8'h00, 32'h0}));
    exp_res.push_back(64'({1'b0, 32'h600D600D}));
    strobe(0, 0, 1, '0);
    tick; tick;
    chk("post_reset_addr", 64'(bus.mem_address), 64'h01);

    tick; tick;
    chk("bus_queue_drained", 64'(exp_bus.size()), 64'd0);
    chk("res_queue_drained", 64'(exp_res.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/nios2_debug_ocimem_sequencer.md
NIOS2_DEBUG_OCIMEM_SEQUENCER -- requirements
Module: nios2_debug_ocimem_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the number of cycles mem_waitrequest may stall one access before abort (range 1..255).
REQ-002 clk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-003 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 take_action_ocimem_a  in  1  SHALL be a one-cycle strobe requesting an address load, with an optional read.
REQ-005 take_no_action_ocimem_a  in  1  SHALL be a one-cycle strobe requesting a read at ADDR, then ADDR increment.
REQ-006 take_action_ocimem_b  in  1  SHALL be a one-cycle strobe requesting a write at ADDR, then ADDR increment.
REQ-007 jdo  in  38  SHALL carry the debug command: [35] read-after-load, [34:3] write data, [17:10] address.
REQ-008 debugack  in  1  SHALL indicate the CPU is halted in debug mode.
REQ-009 mem_readdata  in  32 and mem_waitrequest  in  1 SHALL be the debug-memory response.
REQ-010 mem_address  out  8, mem_read  out  1, mem_write  out  1, mem_writedata  out  32 SHALL drive the debug memory.
REQ-011 MonDReg  out  32, monitor_ready  out  1, monitor_error  out  1 SHALL report the result to the debug slave.
REQ-012 busy  out  1 SHALL be high whenever the FSM is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, RD, WR; RD/WR return to IDLE on completion or abort.
REQ-014 Strobes SHALL be accepted only in IDLE; priority when simultaneous: take_action_ocimem_a > take_action_ocimem_b > take_no_action_ocimem_a; lower-priority strobes are dropped.
REQ-015 take_action_ocimem_a SHALL load ADDR from jdo[17:10] and clear monitor_ready; if jdo[35]=1, go to RD at the new ADDR in the next cycle, otherwise stay IDLE.
REQ-016 take_no_action_ocimem_a SHALL clear monitor_ready and go to RD at the current ADDR.
REQ-017 take_action_ocimem_b with debugack=1 SHALL latch jdo[34:3] into mem_writedata, clear monitor_ready, and go to WR; with debugack=0 it SHALL be rejected, setting monitor_error=1 and monitor_ready=1 with no bus access.
REQ-018 mem_read (in RD) and mem_write (in WR) SHALL be registered, asserted from the cycle after acceptance, and held, with mem_address=ADDR stable, until a cycle with mem_waitrequest=0.
REQ-019 RD completion SHALL capture mem_readdata into MonDReg; monitor_ready SHALL rise one cycle later (zero-wait latency: strobe cycle N, mem_read in N+1, monitor_ready in N+2).
REQ-020 WR completion SHALL set monitor_ready=1 and leave MonDReg unchanged.
REQ-021 After RD/WR completion from take_no_action_ocimem_a or take_action_ocimem_b, ADDR SHALL increment modulo 256 (0xFF -> 0x00); reads launched by take_action_ocimem_a with jdo[35]=1 SHALL not increment ADDR.
REQ-022 Any ocimem strobe arriving while busy=1 SHALL be ignored and SHALL set monitor_error=1 (overrun).
REQ-023 monitor_error SHALL be sticky, cleared only by take_action_ocimem_a or reset.

Reset
REQ-024 On reset_n=0, immediately: state=IDLE, ADDR=0, mem_read=0, mem_write=0, mem_writedata=0, MonDReg=0, monitor_ready=0, monitor_error=0, busy=0, timeout counter=0.
REQ-025 Reset asserted mid-access SHALL abort the access with no result update; the first accepted strobe after release starts cleanly.

Configuration
REQ-026 Macro NIOS2_DEBUG_OCIMEM_TIMEOUT_EN defined: an 8-bit counter SHALL count stalled cycles per access; on reaching TIMEOUT_CYCLES the FSM SHALL deassert mem_read/mem_write, set MonDReg=32'hDEADDEAD, set monitor_error=1 and monitor_ready=1, go to IDLE, and leave ADDR unchanged.
REQ-027 Macro undefined: the FSM SHALL wait indefinitely on mem_waitrequest, no counter is built, and TIMEOUT_CYCLES SHALL be unused.

Verification
REQ-028 take_action_ocimem_a with jdo[17:10]=0x10, jdo[35]=1; mem_readdata=0x12345678, waitrequest=0 -> mem_read for 1 cycle at address 0x10, MonDReg=0x12345678, monitor_ready at N+2, ADDR remains 0x10.
REQ-029 debugack=1; ADDR=0xFF; take_action_ocimem_b with data 0xA5A5A5A5; waitrequest high for 3 cycles -> mem_write held for 4 cycles at address 0xFF, then ADDR=0x00 and monitor_ready=1.
REQ-030 debugack=0; take_action_ocimem_b -> no mem_write, monitor_error=1, monitor_ready=1; a following take_action_ocimem_a clears monitor_error.
REQ-031 take_action_ocimem_b and take_no_action_ocimem_a in the same cycle, then take_no_action_ocimem_a while busy -> only the write occurs and monitor_error=1.
REQ-032 TIMEOUT_EN defined, TIMEOUT_CYCLES=4, waitrequest stuck high on a read -> abort after 4 stall cycles with MonDReg=0xDEADDEAD and monitor_error=1; macro undefined -> mem_read stays high for 100+ cycles.
REQ-033 reset_n pulsed low during WR -> mem_write drops asynchronously and all outputs take their REQ-024 values.
